argmax_reader_m3: RTL and testbench
===================================

# argmax_reader_m3

Output-layer classifier that drains the layer-2 accumulator register file after layer 2 signals completion. On a rising edge of `M2done` it walks `raddr` over all class entries, reads each signed 32-bit score from `regf_data`, tracks the running maximum, and reports the winning class index with a completion pulse. It sits directly downstream of the layer-2 datapath, driving that block's register-file read address and consuming its read data.

## Interface
Parameters:
- `N_CLASS`, 10, number of class scores in the register file (addresses 0..N_CLASS-1)
- `ADDR_W`, 4, width of `raddr` and `class_idx`
- `DATA_W`, 32, width of each score (signed two's complement)

Ports:
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `M2done`  input  1  layer-2 complete level; rising edge starts a read sweep
- `regf_data`  input  DATA_W  register-file read data for the current `raddr` (combinational read)
- `raddr`  output  ADDR_W  register-file read address
- `busy`  output  1  high while a sweep is in progress
- `class_idx`  output  ADDR_W  index of maximum score from the last completed sweep
- `max_val`  output  DATA_W  maximum score from the last completed sweep
- `M3done`  output  1  one-cycle pulse when a new result is valid
- `OVER`  output  1  level: result valid, held until the next sweep starts

## Operation
- Reset (`rst`=0, async): state IDLE; `raddr`=0, `busy`=0, `class_idx`=0, `max_val`=0, `M3done`=0, `OVER`=0, internal `M2done` delay register=0, working max/index=0.
- Start detect: `m2_q` samples `M2done` every cycle; start = `M2done & ~m2_q`. `M2done` already high at reset release counts as a start.
- FSM states: IDLE, READ, DONE.
  - IDLE: `raddr` held at 0. On start: -> READ, `busy`<=1, `OVER`<=0.
  - READ: each edge samples `regf_data` for current `raddr`. Address 0: load working max = data, working index = 0 unconditionally. Address k>0: if `$signed(regf_data) > $signed(work_max)` (strict) replace max and index with data and k; ties keep lower index. `raddr` increments after each sample. On sampling address N_CLASS-1: `class_idx`/`max_val` <= final working values (including that last compare), `raddr`<=0, -> DONE.
  - DONE: `M3done`=1 for this one cycle, `OVER`=1, `busy`=0; -> IDLE.
- `class_idx`/`max_val` change only at sweep completion; hold previous result during a sweep.
- Start edges while in READ or DONE are ignored (not queued); `m2_q` still tracks `M2done`.
- `raddr` never exceeds N_CLASS-1.
- Comparison is full-width signed; no saturation or truncation.

## Timing
- Edge E0: start sampled in IDLE; `raddr`=0, `busy`=1 after E0.
- Edges E1..E_N (N=N_CLASS): sample addresses 0..N-1; `raddr`=k between E_k and E_{k+1}.
- After E_N: `class_idx`, `max_val` valid; `M3done`=1, `OVER`=1, `busy`=0.
- After E_{N+1}: `M3done`=0, IDLE; earliest next start sampled at E_{N+1}.
- Start-to-`M3done` latency: N_CLASS+1 edges (11 by default). `busy` high N_CLASS cycles.
- `regf_data` must be stable within the cycle `raddr` is presented (combinational register-file read).
- Reset mid-sweep aborts immediately; outputs return to reset values; no `M3done`.

## Test plan
- Distinct positives: scores 100,200,...,1000 at 0..9, raise `M2done` -> `M3done` pulse 11 edges after start, `class_idx`=9, `max_val`=1000, `OVER`=1.
- All negative: scores -50 except addr 4 = -3 -> `class_idx`=4, `max_val`=-3 (0xFFFFFFFD); verifies signed compare vs unsigned (0x80000000 at addr 7 must not win).
- Ties: addr 2 and addr 6 both 0x7FFFFFFF, rest 0 -> `class_idx`=2.
- Held `M2done` and re-trigger: hold `M2done` high 30 cycles -> exactly one sweep; drop then raise -> second sweep, `OVER` clears at start, new result replaces old.
- Start during sweep: pulse `M2done` low/high at sweep cycle 5 -> ignored, single `M3done`, `raddr` sequence 0..9 uninterrupted.
- Reset mid-sweep: assert `rst`=0 at address 5 -> all outputs 0 asynchronously; after release with `M2done` low, stays IDLE; next start gives correct full result.

Source files
------------

// File: rtl/argmax_reader_m3.sv
// argmax_reader_m3
//
// Output-layer classifier. When the layer-2 block raises M2done, this block
// walks raddr over every class entry of the layer-2 accumulator register file,
// reads each signed score from regf_data (combinational read), keeps a
// running maximum and reports the winning class with a one-cycle M3done pulse.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   M2done     in   layer-2 complete level; a rising edge starts a sweep
//   regf_data  in   DATA_W score for the address currently on raddr
//   raddr      out  ADDR_W register-file read address
//   busy       out  high while a sweep is in progress
//   class_idx  out  index of the maximum score of the last completed sweep
//   max_val    out  maximum score of the last completed sweep
//   M3done     out  one-cycle pulse when a new result is valid
//   OVER       out  result-valid level, cleared when the next sweep starts
//   dbg_state  out  current FSM state (IDLE=0, READ=1, DONE=2)
//
// Handshake: there is no back-pressure. A sweep is requested by a 0->1
// transition of M2done seen in IDLE; requests arriving while READ or DONE
// are dropped. The register file must present regf_data for raddr within
// the same cycle. The result is qualified by M3done (pulse) or OVER (level).
module argmax_reader_m3 #(
    parameter int N_CLASS = 10,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M2done,
    input  logic [DATA_W-1:0] regf_data,
    output logic [ADDR_W-1:0] raddr,
    output logic              busy,
    output logic [ADDR_W-1:0] class_idx,
    output logic [DATA_W-1:0] max_val,
    output logic              M3done,
    output logic              OVER,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CLASS - 1);

    logic [1:0]        state_q,     state_d;
    logic              m2_q;
    logic [ADDR_W-1:0] raddr_q,     raddr_d;
    logic              busy_q,      busy_d;
    logic [ADDR_W-1:0] class_idx_q, class_idx_d;
    logic [DATA_W-1:0] max_val_q,   max_val_d;
    logic              m3done_q,    m3done_d;
    logic              over_q,      over_d;
    logic [DATA_W-1:0] work_max_q,  work_max_d;
    logic [ADDR_W-1:0] work_idx_q,  work_idx_d;

    logic              start;
    logic              take_new;
    logic [DATA_W-1:0] cand_max;
    logic [ADDR_W-1:0] cand_idx;

    // m2_q resets to 0, so M2done already high at reset release is a start.
    assign start = M2done & ~m2_q;

    // Address 0 seeds the running max unconditionally; later addresses
    // replace it only on a strictly greater signed score, so ties keep the
    // lower index.
    assign take_new = (raddr_q == '0) ||
                      ($signed(regf_data) > $signed(work_max_q));
    assign cand_max = take_new ? regf_data : work_max_q;
    assign cand_idx = take_new ? raddr_q   : work_idx_q;

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        busy_d      = busy_q;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        m3done_d    = 1'b0;
        over_d      = over_q;
        work_max_d  = work_max_q;
        work_idx_d  = work_idx_q;

        case (state_q)
            S_IDLE: begin
                raddr_d = '0;
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    over_d  = 1'b0;
                end
            end
            S_READ: begin
                work_max_d = cand_max;
                work_idx_d = cand_idx;
                if (raddr_q == LAST_ADDR) begin
                    // Publish including the compare of the last entry.
                    class_idx_d = cand_idx;
                    max_val_d   = cand_max;
                    raddr_d     = '0;
                    busy_d      = 1'b0;
                    m3done_d    = 1'b1;
                    over_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    raddr_d = raddr_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                raddr_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            m2_q        <= 1'b0;
            raddr_q     <= '0;
            busy_q      <= 1'b0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            m3done_q    <= 1'b0;
            over_q      <= 1'b0;
            work_max_q  <= '0;
            work_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            m2_q        <= M2done;
            raddr_q     <= raddr_d;
            busy_q      <= busy_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
            m3done_q    <= m3done_d;
            over_q      <= over_d;
            work_max_q  <= work_max_d;
            work_idx_q  <= work_idx_d;
        end
    end

    assign raddr     = raddr_q;
    assign busy      = busy_q;
    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;
    assign M3done    = m3done_q;
    assign OVER      = over_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_argmax_reader_m3.sv
// Testbench for argmax_reader_m3: directed scenarios plus randomized sweeps,
// checked every cycle against a timeline model of the sweep and an argmax
// reference over the score array.
module tb_argmax_reader_m3;

    localparam int N_CLASS = 10;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              M2done = 1'b0;
    logic [DATA_W-1:0] regf_data;
    logic [ADDR_W-1:0] raddr;
    logic              busy;
    logic [ADDR_W-1:0] class_idx;
    logic [DATA_W-1:0] max_val;
    logic              M3done;
    logic              OVER;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] scores [N_CLASS];

    // Combinational register file seen by the DUT.
    assign regf_data = (int'(raddr) < N_CLASS) ? scores[raddr] : 32'hDEAD_BEEF;

    argmax_reader_m3 #(.N_CLASS(N_CLASS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .M2done    (M2done),
        .regf_data (regf_data),
        .raddr     (raddr),
        .busy      (busy),
        .class_idx (class_idx),
        .max_val   (max_val),
        .M3done    (M3done),
        .OVER      (OVER),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int m3_count = 0;
    logic chk_en = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference argmax: first index holding the largest signed score.
    function automatic void ref_argmax(output logic [ADDR_W-1:0] idx, output logic [DATA_W-1:0] mx);
        idx = '0;
        mx  = scores[0];
        for (int k = 1; k < N_CLASS; k++) begin
            if ($signed(scores[k]) > $signed(mx)) begin
                mx  = scores[k];
                idx = ADDR_W'(k);
            end
        end
    endfunction

    // ---------------- behavioural model ----------------
    // phase = -1 when idle, otherwise the number of edges since the start
    // edge; phase N_CLASS is the result cycle.
    int                phase;
    logic              prev_m2;
    logic              mdl_start;
    logic [ADDR_W-1:0] exp_raddr;
    logic              exp_busy;
    logic [ADDR_W-1:0] exp_idx;
    logic [DATA_W-1:0] exp_max;
    logic              exp_m3;
    logic              exp_over;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     = -1;
            prev_m2   = 1'b0;
            exp_raddr = '0;
            exp_busy  = 1'b0;
            exp_idx   = '0;
            exp_max   = '0;
            exp_m3    = 1'b0;
            exp_over  = 1'b0;
        end else begin
            mdl_start = M2done && !prev_m2;
            prev_m2   = M2done;
            exp_m3    = 1'b0;
            if (phase < 0) begin
                if (mdl_start) begin
                    phase     = 0;
                    exp_busy  = 1'b1;
                    exp_over  = 1'b0;
                    exp_raddr = '0;
                end
            end else if (phase < N_CLASS) begin
                phase++;
                if (phase == N_CLASS) begin
                    ref_argmax(exp_idx, exp_max);
                    exp_busy  = 1'b0;
                    exp_m3    = 1'b1;
                    exp_over  = 1'b1;
                    exp_raddr = '0;
                    exp_q.push_back({exp_idx, exp_max});
                end else begin
                    exp_raddr = ADDR_W'(phase);
                end
            end else begin
                phase = -1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [ADDR_W+DATA_W-1:0] popped;
    always @(negedge clk) begin
        if (chk_en) begin
            check("raddr",     raddr,     exp_raddr);
            check("busy",      busy,      exp_busy);
            check("M3done",    M3done,    exp_m3);
            check("OVER",      OVER,      exp_over);
            check("class_idx", class_idx, exp_idx);
            check("max_val",   max_val,   exp_max);
            check("raddr_range", (int'(raddr) < N_CLASS), 1'b1);
            if (M3done) begin
                m3_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result: M3done with no expected result at %0t", $time);
                end else begin
                    popped = exp_q.pop_front();
                    check("result", {class_idx, max_val}, popped);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge where M3done is seen,
    // counting negedges waited.
    task automatic wait_m3(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!M3done && cnt < 40);
        if (!M3done) begin
            total++;
            bad++;
            $display("FAIL wait_m3: timeout after %0d cycles", cnt);
        end
    endtask

    task automatic run_sweep(output int lat);
        M2done = 1'b1;
        wait_m3(lat);
    endtask

    task automatic idle_low(input int n);
        M2done = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int base;
        int cnt;
        for (int k = 0; k < N_CLASS; k++) scores[k] = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_over", OVER, 1'b0);
        check("rst_max",  max_val, 32'd0);
        check("rst_raddr", raddr, 4'd0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Distinct positives, then hold M2done high: exactly one sweep.
        for (int k = 0; k < N_CLASS; k++) scores[k] = 32'(100 * (k + 1));
        base = m3_count;
        run_sweep(lat);
        check("t1_latency", lat, N_CLASS + 1);
        check("t1_idx", class_idx, 4'd9);
        check("t1_max", max_val, 32'd1000);
        check("t1_over", OVER, 1'b1);
        repeat (30) @(negedge clk);
        check("t1_single", m3_count - base, 1);
        check("t1_over_hold", OVER, 1'b1);

        // All negative with 0x80000000 present; retrigger clears OVER.
        idle_low(2);
        for (int k = 0; k < N_CLASS; k++) scores[k] = -32'sd50;
        scores[4] = -32'sd3;
        scores[7] = 32'h8000_0000;
        M2done = 1'b1;
        @(negedge clk);
        check("t2_over_clr", OVER, 1'b0);
        check("t2_old_held", max_val, 32'd1000);
        wait_m3(lat);
        check("t2_idx", class_idx, 4'd4);
        check("t2_max", max_val, 32'hFFFF_FFFD);

        // Ties at the largest positive value: lower index wins.
        idle_low(3);
        for (int k = 0; k < N_CLASS; k++) scores[k] = '0;
        scores[2] = 32'h7FFF_FFFF;
        scores[6] = 32'h7FFF_FFFF;
        run_sweep(lat);
        check("t3_idx", class_idx, 4'd2);
        check("t3_max", max_val, 32'h7FFF_FFFF);

        // Start edge mid-sweep is ignored.
        idle_low(2);
        for (int k = 0; k < N_CLASS; k++) scores[k] = $urandom;
        base = m3_count;
        M2done = 1'b1;
        repeat (5) @(negedge clk);
        M2done = 1'b0;
        @(negedge clk);
        M2done = 1'b1;
        wait_m3(lat);
        check("t4_cycles", lat, N_CLASS - 5);
        repeat (20) @(negedge clk);
        check("t4_single", m3_count - base, 1);

        // Reset in the middle of a sweep.
        idle_low(2);
        base = m3_count;
        M2done = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (raddr != 4'd5 && cnt < 20);
        check("t5_reach5", raddr, 4'd5);
        #2 rst = 1'b0;
        #1;
        check("t5_raddr", raddr, 4'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_over", OVER, 1'b0);
        check("t5_idx", class_idx, 4'd0);
        check("t5_max", max_val, 32'd0);
        M2done = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_idle", busy, 1'b0);
        check("t5_no_done", m3_count - base, 0);
        for (int k = 0; k < N_CLASS; k++) scores[k] = 32'd5;
        scores[3] = 32'd77;
        run_sweep(lat);
        check("t5_latency", lat, N_CLASS + 1);
        check("t5_res_idx", class_idx, 4'd3);
        check("t5_res_max", max_val, 32'd77);

        // Randomized sweeps.
        for (int it = 0; it < 30; it++) begin
            idle_low($urandom_range(1, 4));
            for (int k = 0; k < N_CLASS; k++) begin
                case ($urandom_range(0, 2))
                    0: scores[k] = $urandom;
                    1: scores[k] = 32'($urandom_range(0, 6)) - 32'd3;
                    default: scores[k] = 32'h8000_0000 | 32'($urandom_range(0, 3));
                endcase
            end
            M2done = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 6)) @(negedge clk);
                M2done = 1'b0;
                @(negedge clk);
                M2done = 1'b1;
            end
            wait_m3(lat);
        end

        idle_low(5);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
